// File: rtl/i2c_req_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_arb_pkg
// Brief    : State and status encodings shared by the I2C request arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package i2c_arb_pkg;

    localparam int STATE_W = 3;

    localparam logic [STATE_W-1:0] IDLE      = 3'd0;
    localparam logic [STATE_W-1:0] GRANT     = 3'd1;
    localparam logic [STATE_W-1:0] LAUNCH    = 3'd2;
    localparam logic [STATE_W-1:0] WAIT_BUSY = 3'd3;
    localparam logic [STATE_W-1:0] WAIT_DONE = 3'd4;
    localparam logic [STATE_W-1:0] RESP      = 3'd5;

    localparam logic [1:0] ERR_OK   = 2'd0;
    localparam logic [1:0] ERR_NACK = 2'd1;
    localparam logic [1:0] ERR_TO   = 2'd2;

endpackage : i2c_arb_pkg
`default_nettype wire

// File: rtl/i2c_req_arbiter_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter_if
// Brief    : Requester-side and engine-side signal bundle of the arbiter.
//            master = arbiter view, slave = requesters/engine view.
// Revision : 1.0 - initial release
// ============================================================================
interface i2c_req_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]   req;
    logic [8*NUM_REQ-1:0] req_addr;
    logic [8*NUM_REQ-1:0] req_wdata;
    logic [NUM_REQ-1:0]   gnt;
    logic [NUM_REQ-1:0]   done;
    logic [15:0]          rdata;
    logic [1:0]           err;
    logic                 i2c_en;
    logic [7:0]           i2c_addr;
    logic [7:0]           i2c_data;
    logic                 i2c_busy;
    logic                 i2c_done;
    logic                 i2c_nack;
    logic [15:0]          i2c_rdata;

    modport master (
        input  req, req_addr, req_wdata, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
        output gnt, done, rdata, err, i2c_en, i2c_addr, i2c_data
    );

    modport slave (
        output req, req_addr, req_wdata, i2c_busy, i2c_done, i2c_nack, i2c_rdata,
        input  gnt, done, rdata, err, i2c_en, i2c_addr, i2c_data
    );

endinterface : i2c_req_arbiter_if
`default_nettype wire

// File: rtl/i2c_req_arbiter_rr_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin pick: first set request at or after
//            the pointer, wrapping. Pointer register lives in the parent.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_ptr,
    output logic      [NUM_REQ-1:0] o_onehot,
    output logic      [IDX_W-1:0]   o_idx,
    output logic                    o_any
);

    always_comb begin
        int w_cand;
        w_cand   = 0;
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_cand = (int'(i_ptr) + k) % NUM_REQ;
            if (!o_any && i_req[w_cand]) begin
                o_any            = 1'b1;
                o_onehot[w_cand] = 1'b1;
                o_idx            = IDX_W'(w_cand);
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/i2c_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : i2c_req_arbiter
// Brief    : Round-robin sharing of one I2C engine among NUM_REQ requesters.
//            Optional NACK retry enabled by defining I2C_ARB_RETRY_EN.
// Revision : 1.0 - initial release
// ============================================================================
module i2c_req_arbiter
    import i2c_arb_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int TIMEOUT_CYC = 200000
`ifdef I2C_ARB_RETRY_EN
   ,parameter int MAX_RETRY   = 2
`endif
) (
    input  wire logic          clk_sys,
    input  wire logic          rst,
    i2c_req_arbiter_if.master  bus
);

    localparam int c_IDX_W = $clog2(NUM_REQ);
    localparam int c_CNT_W = $clog2(TIMEOUT_CYC);

    logic [STATE_W-1:0] r_state;
    logic [STATE_W-1:0] w_state_nxt;
    logic [NUM_REQ-1:0] r_gnt;
    logic [c_IDX_W-1:0] r_gnt_idx;
    logic [c_IDX_W-1:0] r_ptr;
    logic [c_CNT_W-1:0] r_to_cnt;
    logic [NUM_REQ-1:0] r_done;
    logic [15:0]        r_rdata;
    logic [1:0]         r_err;
    logic               r_i2c_en;
    logic [7:0]         r_i2c_addr;
    logic [7:0]         r_i2c_data;

    logic [NUM_REQ-1:0] w_onehot;
    logic [c_IDX_W-1:0] w_idx;
    logic               w_any;
    logic               w_timeout;
    logic               w_retry;
    logic [1:0]         w_resp_err;
    logic [15:0]        w_resp_rdata;

`ifdef I2C_ARB_RETRY_EN
    localparam int c_RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    logic [c_RETRY_W-1:0] r_retry;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_rr_arbiter (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_onehot),
        .o_idx    (w_idx),
        .o_any    (w_any)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = (r_to_cnt == c_CNT_W'(TIMEOUT_CYC - 1));
`ifdef I2C_ARB_RETRY_EN
        w_retry     = bus.i2c_nack && (r_retry < c_RETRY_W'(MAX_RETRY));
`else
        w_retry     = 1'b0;
`endif
        // Engine completion wins over a timeout landing in the same cycle.
        if (bus.i2c_done) begin
            w_resp_err   = bus.i2c_nack ? ERR_NACK : ERR_OK;
            w_resp_rdata = (r_i2c_addr[0] && !bus.i2c_nack) ? bus.i2c_rdata : 16'h0000;
        end else begin
            w_resp_err   = ERR_TO;
            w_resp_rdata = 16'h0000;
        end

        case (r_state)
            IDLE:      if (|bus.req) w_state_nxt = GRANT;
            GRANT:     w_state_nxt = w_any ? LAUNCH : IDLE;
            LAUNCH:    w_state_nxt = WAIT_BUSY;
            WAIT_BUSY: begin
                if (bus.i2c_done)      w_state_nxt = w_retry ? LAUNCH : RESP;
                else if (w_timeout)    w_state_nxt = RESP;
                else if (bus.i2c_busy) w_state_nxt = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (bus.i2c_done)      w_state_nxt = w_retry ? LAUNCH : RESP;
                else if (w_timeout)    w_state_nxt = RESP;
            end
            RESP:      w_state_nxt = IDLE;
            default:   w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_gnt_idx  <= '0;
            r_ptr      <= '0;
            r_to_cnt   <= '0;
            r_done     <= '0;
            r_rdata    <= 16'h0000;
            r_err      <= ERR_OK;
            r_i2c_en   <= 1'b0;
            r_i2c_addr <= 8'h00;
            r_i2c_data <= 8'h00;
        end else begin
            r_state  <= w_state_nxt;
            r_i2c_en <= (r_state == LAUNCH);
            r_done   <= '0;

            case (r_state)
                GRANT: begin
                    if (w_any) begin
                        r_gnt      <= w_onehot;
                        r_gnt_idx  <= w_idx;
                        r_i2c_addr <= bus.req_addr[8*w_idx +: 8];
                        r_i2c_data <= bus.req_wdata[8*w_idx +: 8];
                    end
                end
                LAUNCH:    r_to_cnt <= '0;
                WAIT_BUSY,
                WAIT_DONE: r_to_cnt <= r_to_cnt + c_CNT_W'(1);
                RESP: begin
                    r_gnt <= '0;
                    r_ptr <= (r_gnt_idx == c_IDX_W'(NUM_REQ - 1)) ? '0
                                                                  : r_gnt_idx + c_IDX_W'(1);
                end
                default: ;
            endcase

            // Response fields are registered on entry so they appear during RESP.
            if ((w_state_nxt == RESP) && (r_state != RESP)) begin
                r_done  <= r_gnt;
                r_rdata <= w_resp_rdata;
                r_err   <= w_resp_err;
            end
        end
    end

`ifdef I2C_ARB_RETRY_EN
    always_ff @(posedge clk_sys) begin
        if (rst) begin
            r_retry <= '0;
        end else if (r_state == GRANT) begin
            r_retry <= '0;
        end else if (((r_state == WAIT_BUSY) || (r_state == WAIT_DONE))
                     && bus.i2c_done && w_retry) begin
            r_retry <= r_retry + c_RETRY_W'(1);
        end
    end
`endif

    assign bus.gnt      = r_gnt;
    assign bus.done     = r_done;
    assign bus.rdata    = r_rdata;
    assign bus.err      = r_err;
    assign bus.i2c_en   = r_i2c_en;
    assign bus.i2c_addr = r_i2c_addr;
    assign bus.i2c_data = r_i2c_data;

endmodule : i2c_req_arbiter
`default_nettype wire

// File: tb/tb_i2c_req_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_i2c_req_arbiter
// Brief    : Directed scoreboard bench with a behavioural I2C engine model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2c_req_arbiter;
    import i2c_arb_pkg::*;

    localparam int NUM_REQ     = 4;
    localparam int TIMEOUT_CYC = 2000;
`ifdef I2C_ARB_RETRY_EN
    localparam int C_NACK_EN   = 3;
`else
    localparam int C_NACK_EN   = 1;
`endif

    logic clk_sys = 1'b0;
    logic rst     = 1'b1;
    always #5 clk_sys = ~clk_sys;

    i2c_req_arbiter_if #(.NUM_REQ(NUM_REQ)) bus();

    i2c_req_arbiter #(
        .NUM_REQ     (NUM_REQ),
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) dut (
        .clk_sys (clk_sys),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        logic [3:0]  done;
        logic [15:0] rdata;
        logic [1:0]  err;
        logic [7:0]  addr;
        logic [7:0]  data;
        int          en_cnt;
        int          lat;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   n_checks = 0;
    int   n_err    = 0;
    int   cyc      = 0;
    int   en_cnt   = 0;
    int   last_en  = 0;

    int          eng_delay  = 1000;
    bit          eng_nack   = 1'b0;
    bit          eng_silent = 1'b0;
    logic [15:0] eng_rdata  = 16'h0000;

    always @(posedge clk_sys) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void expect_tx(input logic [3:0] d, input logic [15:0] r,
                                      input logic [1:0] er, input logic [7:0] a,
                                      input logic [7:0] w, input int n, input int lat);
        exp_t x;
        x.done = d; x.rdata = r; x.err = er; x.addr = a; x.data = w;
        x.en_cnt = n; x.lat = lat;
        sb.push_back(x);
    endfunction

    task automatic set_req(input int idx, input logic [7:0] addr, input logic [7:0] wdata);
        bus.req_addr[8*idx +: 8]  = addr;
        bus.req_wdata[8*idx +: 8] = wdata;
        bus.req[idx]              = 1'b1;
    endtask

    task automatic wait_done(input int idx, input int budget);
        int k;
        for (k = 0; k < budget; k++) begin
            @(negedge clk_sys);
            if (bus.done[idx]) break;
        end
        if (k == budget) begin
            n_checks++;
            n_err++;
            $display("FAIL wait_done[%0d]: got no done, required one within %0d cycles", idx, budget);
        end
        bus.req[idx] = 1'b0;
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_gnt"},   bus.gnt,      0);
        chk({tag, "_done"},  bus.done,     0);
        chk({tag, "_rdata"}, bus.rdata,    0);
        chk({tag, "_err"},   bus.err,      0);
        chk({tag, "_en"},    bus.i2c_en,   0);
        chk({tag, "_addr"},  bus.i2c_addr, 0);
        chk({tag, "_data"},  bus.i2c_data, 0);
    endtask

    // Engine model: busy for eng_delay cycles after a start, then a done pulse.
    initial begin
        bus.i2c_busy  = 1'b0;
        bus.i2c_done  = 1'b0;
        bus.i2c_nack  = 1'b0;
        bus.i2c_rdata = 16'h0000;
        forever begin
            @(negedge clk_sys);
            if (bus.i2c_en && !eng_silent) begin
                bus.i2c_busy = 1'b1;
                repeat (eng_delay) @(negedge clk_sys);
                bus.i2c_busy  = 1'b0;
                bus.i2c_done  = 1'b1;
                bus.i2c_nack  = eng_nack;
                bus.i2c_rdata = eng_rdata;
                @(negedge clk_sys);
                bus.i2c_done  = 1'b0;
                bus.i2c_nack  = 1'b0;
                bus.i2c_rdata = 16'h0000;
            end
        end
    end

    // Monitor: pops one expectation per done pulse.
    initial begin
        forever begin
            @(negedge clk_sys);
            if (rst) begin
                en_cnt = 0;
            end else begin
                if (bus.i2c_en) begin
                    en_cnt++;
                    last_en = cyc;
                end
                if (|bus.done) begin
                    if (sb.size() == 0) begin
                        n_checks++;
                        n_err++;
                        $display("FAIL unexpected_done: got done=%b, required none", bus.done);
                    end else begin
                        e = sb.pop_front();
                        chk("done",     bus.done,     e.done);
                        chk("gnt",      bus.gnt,      e.done);
                        chk("rdata",    bus.rdata,    e.rdata);
                        chk("err",      bus.err,      e.err);
                        chk("i2c_addr", bus.i2c_addr, e.addr);
                        chk("i2c_data", bus.i2c_data, e.data);
                        chk("en_pulses", en_cnt,      e.en_cnt);
                        if (e.lat > 0) chk("to_latency", cyc - last_en, e.lat);
                    end
                    en_cnt = 0;
                end
            end
        end
    end

    initial begin
        int k;
        int nd;
        bus.req       = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        rst           = 1'b1;
        repeat (3) @(negedge clk_sys);
        chk_outputs_zero("reset");
        rst = 1'b0;
        @(negedge clk_sys);

        // Single write with grant/start latency checks.
        eng_delay = 1000; eng_nack = 1'b0; eng_rdata = 16'h0000;
        expect_tx(4'b0001, 16'h0000, ERR_OK, 8'h34, 8'hA5, 1, 0);
        set_req(0, 8'h34, 8'hA5);
        @(negedge clk_sys);
        chk("gnt_lat_n1", bus.gnt, 4'b0000);
        @(negedge clk_sys);
        chk("gnt_lat_n2", bus.gnt, 4'b0001);
        chk("en_lat_n2",  bus.i2c_en, 1'b0);
        @(negedge clk_sys);
        chk("en_lat_n3",  bus.i2c_en, 1'b1);
        wait_done(0, 1500);
        @(negedge clk_sys);

        // Read returning data.
        eng_delay = 20; eng_rdata = 16'hBEEF;
        expect_tx(4'b0100, 16'hBEEF, ERR_OK, 8'h35, 8'h77, 1, 0);
        set_req(2, 8'h35, 8'h77);
        wait_done(2, 200);
        @(negedge clk_sys);

        // Fairness from a fresh pointer.
        rst = 1'b1;
        @(negedge clk_sys);
        rst = 1'b0;
        eng_delay = 5; eng_rdata = 16'h0000;
        expect_tx(4'b0001, 16'h0000, ERR_OK, 8'h20, 8'hC0, 1, 0);
        expect_tx(4'b0010, 16'h0000, ERR_OK, 8'h22, 8'hC1, 1, 0);
        expect_tx(4'b0100, 16'h0000, ERR_OK, 8'h24, 8'hC2, 1, 0);
        expect_tx(4'b1000, 16'h0000, ERR_OK, 8'h26, 8'hC3, 1, 0);
        expect_tx(4'b0001, 16'h0000, ERR_OK, 8'h20, 8'hC0, 1, 0);
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 8'(8'h20 + 2*i), 8'(8'hC0 + i));
        nd = 0;
        for (k = 0; k < 500 && nd < 5; k++) begin
            @(negedge clk_sys);
            if (|bus.done) nd++;
        end
        bus.req = '0;
        chk("fair_done_count", nd, 5);
        repeat (20) @(negedge clk_sys);

        // NACK on a read: data suppressed, retries only with the feature.
        eng_delay = 10; eng_nack = 1'b1; eng_rdata = 16'h1234;
        expect_tx(4'b0010, 16'h0000, ERR_NACK, 8'h51, 8'h00, C_NACK_EN, 0);
        set_req(1, 8'h51, 8'h00);
        wait_done(1, 300);
        eng_nack = 1'b0; eng_rdata = 16'h0000;
        @(negedge clk_sys);

        // Timeout on requester 3, then requester 0 is served.
        eng_silent = 1'b1;
        expect_tx(4'b1000, 16'h0000, ERR_TO, 8'h66, 8'h3C, 1, TIMEOUT_CYC);
        expect_tx(4'b0001, 16'h0000, ERR_OK, 8'h42, 8'h99, 1, 0);
        set_req(3, 8'h66, 8'h3C);
        set_req(0, 8'h42, 8'h99);
        wait_done(3, TIMEOUT_CYC + 50);
        eng_silent = 1'b0;
        wait_done(0, 100);
        @(negedge clk_sys);

        // Reset while waiting on the engine; the late engine done must be ignored.
        eng_delay = 60;
        set_req(2, 8'h70, 8'h11);
        for (k = 0; k < 20 && !bus.i2c_busy; k++) @(negedge clk_sys);
        chk("mid_busy_seen", bus.i2c_busy, 1'b1);
        repeat (5) @(negedge clk_sys);
        rst     = 1'b1;
        bus.req = '0;
        @(negedge clk_sys);
        chk_outputs_zero("mid_reset");
        rst = 1'b0;
        repeat (100) @(negedge clk_sys);

        // Pointer back at 0: requester 0 beats requester 3.
        eng_delay = 10;
        expect_tx(4'b0001, 16'h0000, ERR_OK, 8'h12, 8'h34, 1, 0);
        expect_tx(4'b1000, 16'h0000, ERR_OK, 8'h56, 8'h78, 1, 0);
        set_req(0, 8'h12, 8'h34);
        set_req(3, 8'h56, 8'h78);
        wait_done(0, 100);
        wait_done(3, 100);
        repeat (10) @(negedge clk_sys);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_i2c_req_arbiter
`default_nettype wire
